// File: rtl/audio_cmd_sequencer.sv
// audio_cmd_sequencer
// Buffers decoded stereo sample packets in a small FIFO and paces them out at
// 44.1 kHz or 22.05 kHz. It tracks stream state (idle, priming, playing),
// raises a refill request at a low-water mark, latches keyboard LED updates,
// and treats the all-ones packet as a soft reset.
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   op, data, op_valid    - command word, payload, qualifier for every event strobe
//   is_audio_sample       - write data[31:16]/data[15:0] (L/R) into the FIFO
//   audio_starts          - start stream; op[15:8]==8'h1f selects 22.05 kHz
//   all_1_packet          - soft reset (keeps led_state, overflow, underrun)
//   keyboard_led_update   - latch data[1:0] into led_state
//   sample_tick           - 44.1 kHz single-cycle strobe
//   audio_l/r, audio_valid- output sample and its one-cycle strobe
//   audio_running         - stream is priming or playing
//   mode_22k              - latched output rate
//   sample_req            - FIFO at or below the low-water mark while running
//   fifo_level            - FIFO occupancy
//   overflow, underrun    - sticky error flags (hardware reset only)
//   led_state, led_update - latched LED bits and one-cycle write strobe
module audio_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned PRIME_LEVEL = 4,
    parameter int unsigned LOW_WATER   = 2,
    parameter int unsigned IDLE_TICKS  = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   op,
    input  logic [31:0]                   data,
    input  logic                          op_valid,
    input  logic                          is_audio_sample,
    input  logic                          audio_starts,
    input  logic                          all_1_packet,
    input  logic                          keyboard_led_update,
    input  logic                          sample_tick,
    output logic [15:0]                   audio_l,
    output logic [15:0]                   audio_r,
    output logic                          audio_valid,
    output logic                          audio_running,
    output logic                          mode_22k,
    output logic                          sample_req,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          underrun,
    output logic [1:0]                    led_state,
    output logic                          led_update
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = 8;
    localparam logic [7:0]  OP_22K = 8'h1f;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_PLAY  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    logic            phase_q, phase_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [15:0]     audio_l_q, audio_l_d;
    logic [15:0]     audio_r_q, audio_r_d;
    logic            audio_valid_q, audio_valid_d;
    logic            running_q, running_d;
    logic            req_q, req_d;
    logic            overflow_q, overflow_d;
    logic            underrun_q, underrun_d;
    logic [1:0]      led_q, led_d;
    logic            led_upd_q, led_upd_d;

    logic [31:0]     mem_q [FIFO_DEPTH];
    logic            play_tick_c;
    logic            pop_c;
    logic            push_c;
    logic            unused_op_bits_c;

    assign unused_op_bits_c = ^op[7:0];

    // Next-state and output computation
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        phase_d       = phase_q;
        starve_d      = starve_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        audio_l_d     = audio_l_q;
        audio_r_d     = audio_r_q;
        audio_valid_d = 1'b0;
        running_d     = running_q;
        req_d         = running_q && (level_q <= LW'(LOW_WATER));
        overflow_d    = overflow_q;
        underrun_d    = underrun_q;
        led_d         = led_q;
        led_upd_d     = 1'b0;
        push_c        = 1'b0;
        play_tick_c   = sample_tick && (state_q == S_PLAY) && (!mode_q || phase_q);
        pop_c         = play_tick_c && (level_q != '0);

        if (op_valid && all_1_packet) begin
            // Soft reset: everything but LED state and sticky flags
            state_d   = S_IDLE;
            mode_d    = 1'b0;
            phase_d   = 1'b0;
            starve_d  = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            audio_l_d = '0;
            audio_r_d = '0;
            req_d     = 1'b0;
            running_d = 1'b0;
            pop_c     = 1'b0;
        end else begin
            // 22 kHz mode plays on every other tick
            if (sample_tick && (state_q == S_PLAY)) begin
                phase_d = ~phase_q;
            end

            if (play_tick_c) begin
                audio_valid_d = 1'b1;
                if (pop_c) begin
                    audio_l_d = mem_q[rd_ptr_q][31:16];
                    audio_r_d = mem_q[rd_ptr_q][15:0];
                    rd_ptr_d  = rd_ptr_q + AW'(1);
                    starve_d  = '0;
                end else begin
                    // Starved tick emits silence; a write this cycle is not bypassed
                    audio_l_d  = '0;
                    audio_r_d  = '0;
                    underrun_d = 1'b1;
                    starve_d   = starve_q + CW'(1);
                    if (starve_d == CW'(IDLE_TICKS)) begin
                        state_d = S_IDLE;
                    end
                end
            end

            // A full FIFO only accepts a write when a pop frees a slot this cycle
            if (op_valid && is_audio_sample) begin
                if ((level_q == LW'(FIFO_DEPTH)) && !pop_c) begin
                    overflow_d = 1'b1;
                end else begin
                    push_c   = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end
            end
            level_d = level_q + LW'(push_c) - LW'(pop_c);

            case (state_q)
                S_IDLE: begin
                    if (op_valid && audio_starts) begin
                        state_d  = S_PRIME;
                        mode_d   = (op[15:8] == OP_22K);
                        phase_d  = 1'b0;
                        starve_d = '0;
                    end
                end
                S_PRIME: begin
                    if (op_valid && audio_starts) begin
                        mode_d = (op[15:8] == OP_22K);
                    end
                    if (level_q >= LW'(PRIME_LEVEL)) begin
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (op_valid && audio_starts) begin
                        mode_d = (op[15:8] == OP_22K);
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (op_valid && keyboard_led_update) begin
                led_d     = data[1:0];
                led_upd_d = 1'b1;
            end

            running_d = (state_d != S_IDLE);
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mode_q        <= 1'b0;
            phase_q       <= 1'b0;
            starve_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            audio_l_q     <= '0;
            audio_r_q     <= '0;
            audio_valid_q <= 1'b0;
            running_q     <= 1'b0;
            req_q         <= 1'b0;
            overflow_q    <= 1'b0;
            underrun_q    <= 1'b0;
            led_q         <= '0;
            led_upd_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            phase_q       <= phase_d;
            starve_q      <= starve_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            audio_l_q     <= audio_l_d;
            audio_r_q     <= audio_r_d;
            audio_valid_q <= audio_valid_d;
            running_q     <= running_d;
            req_q         <= req_d;
            overflow_q    <= overflow_d;
            underrun_q    <= underrun_d;
            led_q         <= led_d;
            led_upd_q     <= led_upd_d;
        end
    end

    // Sample storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    assign audio_l       = audio_l_q;
    assign audio_r       = audio_r_q;
    assign audio_valid   = audio_valid_q;
    assign audio_running = running_q;
    assign mode_22k      = mode_q;
    assign sample_req    = req_q;
    assign fifo_level    = level_q;
    assign overflow      = overflow_q;
    assign underrun      = underrun_q;
    assign led_state     = led_q;
    assign led_update    = led_upd_q;

endmodule

// File: tb/tb_audio_cmd_sequencer.sv
// Testbench for audio_cmd_sequencer: directed packet sequences, a queue-based
// behavioural model compared against every output each cycle, and literal
// expectations for the pop order and flags of each scenario.
module tb_audio_cmd_sequencer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PRIME = 4;
    localparam int unsigned LOWW  = 2;
    localparam int unsigned IDLET = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] op;
    logic [31:0] data;
    logic        op_valid, is_audio_sample, audio_starts, all_1_packet;
    logic        keyboard_led_update, sample_tick;
    logic [15:0] audio_l, audio_r;
    logic        audio_valid, audio_running, mode_22k, sample_req;
    logic [3:0]  fifo_level;
    logic        overflow, underrun;
    logic [1:0]  led_state;
    logic        led_update;

    audio_cmd_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .PRIME_LEVEL(PRIME),
        .LOW_WATER  (LOWW),
        .IDLE_TICKS (IDLET)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .op                 (op),
        .data               (data),
        .op_valid           (op_valid),
        .is_audio_sample    (is_audio_sample),
        .audio_starts       (audio_starts),
        .all_1_packet       (all_1_packet),
        .keyboard_led_update(keyboard_led_update),
        .sample_tick        (sample_tick),
        .audio_l            (audio_l),
        .audio_r            (audio_r),
        .audio_valid        (audio_valid),
        .audio_running      (audio_running),
        .mode_22k           (mode_22k),
        .sample_req         (sample_req),
        .fifo_level         (fifo_level),
        .overflow           (overflow),
        .underrun           (underrun),
        .led_state          (led_state),
        .led_update         (led_update)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_q[$];
    bit          m_priming, m_playing, m_mode, m_phase;
    int          m_starve;
    logic [15:0] m_l, m_r;
    bit          m_valid, m_req, m_ovf, m_unr, m_ledupd;
    logic [1:0]  m_led;
    int          lvl0;
    bit          play0, prime0, popped;
    logic [31:0] w;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_priming = 0; m_playing = 0; m_mode = 0; m_phase = 0; m_starve = 0;
            m_l = '0; m_r = '0; m_valid = 0; m_req = 0; m_ovf = 0; m_unr = 0;
            m_ledupd = 0; m_led = '0;
        end else if (op_valid && all_1_packet) begin
            m_q.delete();
            m_priming = 0; m_playing = 0; m_mode = 0; m_phase = 0; m_starve = 0;
            m_l = '0; m_r = '0; m_valid = 0; m_req = 0; m_ledupd = 0;
        end else begin
            lvl0   = m_q.size();
            play0  = m_playing;
            prime0 = m_priming;
            m_req  = (play0 || prime0) && (lvl0 <= int'(LOWW));
            m_valid  = 0;
            m_ledupd = 0;
            popped   = 0;
            if (sample_tick && play0 && (!m_mode || m_phase)) begin
                m_valid = 1;
                if (lvl0 > 0) begin
                    w = m_q.pop_front();
                    m_l = w[31:16]; m_r = w[15:0];
                    m_starve = 0;
                    popped = 1;
                end else begin
                    m_l = '0; m_r = '0;
                    m_unr = 1;
                    m_starve++;
                    if (m_starve == int'(IDLET)) m_playing = 0;
                end
            end
            if (sample_tick && play0) m_phase = !m_phase;
            if (op_valid && is_audio_sample) begin
                if (lvl0 == int'(DEPTH) && !popped) m_ovf = 1;
                else m_q.push_back(data);
            end
            if (op_valid && audio_starts) begin
                if (!play0 && !prime0) begin
                    m_priming = 1; m_phase = 0; m_starve = 0;
                end
                m_mode = (op[15:8] == 8'h1f);
            end
            if (prime0 && lvl0 >= int'(PRIME)) begin
                m_priming = 0; m_playing = 1;
            end
            if (op_valid && keyboard_led_update) begin
                m_led = data[1:0];
                m_ledupd = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [31:0] got[$];
    int          pop_tick[$];
    int          tick_no;

    always @(negedge clk) begin
        if (!reset) begin
            check("audio_l",       32'(audio_l),       32'(m_l));
            check("audio_r",       32'(audio_r),       32'(m_r));
            check("audio_valid",   32'(audio_valid),   32'(m_valid));
            check("audio_running", 32'(audio_running), 32'(m_priming || m_playing));
            check("mode_22k",      32'(mode_22k),      32'(m_mode));
            check("sample_req",    32'(sample_req),    32'(m_req));
            check("fifo_level",    32'(fifo_level),    32'(m_q.size()));
            check("overflow",      32'(overflow),      32'(m_ovf));
            check("underrun",      32'(underrun),      32'(m_unr));
            check("led_state",     32'(led_state),     32'(m_led));
            check("led_update",    32'(led_update),    32'(m_ledupd));
            if (audio_valid) begin
                got.push_back({audio_l, audio_r});
                pop_tick.push_back(tick_no);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] exp_q[$];
    int          exp_t[$];

    task automatic drive(input bit v, input bit smp, input bit st, input bit a1,
                         input bit kl, input bit tk, input logic [15:0] o, input logic [31:0] d);
        @(negedge clk);
        #1;
        op_valid = v; is_audio_sample = smp; audio_starts = st; all_1_packet = a1;
        keyboard_led_update = kl; sample_tick = tk; op = o; data = d;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 16'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] d);
        drive(1, 1, 0, 0, 0, 0, 16'h0, d);
    endtask

    task automatic start(input logic [15:0] o);
        drive(1, 0, 1, 0, 0, 0, o, 32'h0);
    endtask

    task automatic tick();
        drive(1, 0, 0, 0, 0, 1, 16'h0, 32'h0);
        tick_no++;
        idle();
    endtask

    task automatic clear_logs();
        got.delete();
        pop_tick.delete();
        tick_no = 0;
    endtask

    task automatic hw_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        op_valid = 0; is_audio_sample = 0; audio_starts = 0; all_1_packet = 0;
        keyboard_led_update = 0; sample_tick = 0; op = '0; data = '0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic check_got(input string name);
        check({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) check(name, got[i], exp_q[i]);
            else check(name, 32'hdead_beef, exp_q[i]);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        reset = 1'b1;
        op_valid = 0; is_audio_sample = 0; audio_starts = 0; all_1_packet = 0;
        keyboard_led_update = 0; sample_tick = 0; op = '0; data = '0;
        tick_no = 0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        idle();
        check("rst_level",   32'(fifo_level),    32'd0);
        check("rst_running", 32'(audio_running), 32'd0);
        check("rst_valid",   32'(audio_valid),   32'd0);
        check("rst_led",     32'(led_state),     32'd0);

        // Prime and play at 44.1 kHz
        hw_reset();
        start(16'h0f00);
        wr(32'h1111_2222); wr(32'h2222_3333); wr(32'h3333_4444); wr(32'h4444_5555);
        idle();
        check("p44_level_primed", 32'(fifo_level), 32'd4);
        for (int i = 0; i < 4; i++) tick();
        idle();
        exp_q = {32'h1111_2222, 32'h2222_3333, 32'h3333_4444, 32'h4444_5555};
        check_got("p44_pops");
        check("p44_level_end", 32'(fifo_level), 32'd0);
        check("p44_req_end",   32'(sample_req), 32'd1);
        check("p44_mode",      32'(mode_22k),   32'd0);

        // 22.05 kHz pacing
        hw_reset();
        start(16'h1f00);
        wr(32'hA1A1_0001); wr(32'hA2A2_0002); wr(32'hA3A3_0003); wr(32'hA4A4_0004);
        idle();
        for (int i = 0; i < 8; i++) tick();
        exp_t = {2, 4, 6, 8};
        check("p22_pop_count", 32'(pop_tick.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < pop_tick.size()) check("p22_pop_tick", 32'(pop_tick[i]), 32'(exp_t[i]));
        end
        check("p22_mode", 32'(mode_22k), 32'd1);

        // Overflow while idle; 9th word must never appear
        hw_reset();
        for (int i = 0; i < 9; i++) wr(32'hA000_0000 + 32'(i));
        idle();
        check("ovf_level", 32'(fifo_level), 32'd8);
        check("ovf_flag",  32'(overflow),   32'd1);
        start(16'h0f00);
        idle();
        for (int i = 0; i < 9; i++) tick();
        exp_q = {32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
                 32'hA000_0004, 32'hA000_0005, 32'hA000_0006, 32'hA000_0007, 32'h0};
        check_got("ovf_pops");

        // Full FIFO with pop and write in the same cycle
        hw_reset();
        for (int i = 0; i < 8; i++) wr(32'hB000_0000 + 32'(i));
        start(16'h0f00);
        idle();
        drive(1, 1, 0, 0, 0, 1, 16'h0, 32'hBEEF_0008);
        idle();
        check("full_pw_level", 32'(fifo_level), 32'd8);
        check("full_pw_ovf",   32'(overflow),   32'd0);
        for (int i = 0; i < 8; i++) tick();
        exp_q = {32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003,
                 32'hB000_0004, 32'hB000_0005, 32'hB000_0006, 32'hB000_0007, 32'hBEEF_0008};
        check_got("full_pw_pops");

        // Underrun, write-on-empty tick, and idle timeout
        hw_reset();
        start(16'h0f00);
        wr(32'hC000_0000); wr(32'hC000_0001); wr(32'hC000_0002); wr(32'hC000_0003);
        idle();
        for (int i = 0; i < 4; i++) tick();
        drive(1, 1, 0, 0, 0, 1, 16'h0, 32'hC0DE_0004);
        idle();
        check("unr_wr_level", 32'(fifo_level), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) tick();
        idle();
        exp_q = {32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003,
                 32'h0, 32'hC0DE_0004, 32'h0, 32'h0, 32'h0};
        check_got("unr_pops");
        check("unr_flag",    32'(underrun),      32'd1);
        check("unr_running", 32'(audio_running), 32'd0);

        // Soft reset mid-stream with a same-cycle sample write
        clear_logs();
        drive(1, 0, 0, 0, 1, 0, 16'h0, 32'h0000_0002);
        start(16'h1f00);
        wr(32'hD000_0000); wr(32'hD000_0001); wr(32'hD000_0002); wr(32'hD000_0003);
        idle();
        tick();
        tick();
        check("sr_pre_level", 32'(fifo_level), 32'd3);
        drive(1, 1, 0, 1, 0, 0, 16'h0, 32'hDEAD_0009);
        idle();
        check("sr_level",    32'(fifo_level),    32'd0);
        check("sr_running",  32'(audio_running), 32'd0);
        check("sr_led",      32'(led_state),     32'd2);
        check("sr_underrun", 32'(underrun),      32'd1);
        check("sr_mode",     32'(mode_22k),      32'd0);
        idle();
        check("sr_level_hold", 32'(fifo_level), 32'd0);

        // Asynchronous reset takes effect without a clock edge
        start(16'h0f00);
        wr(32'hE000_0000);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_level",    32'(fifo_level), 32'd0);
        check("async_underrun", 32'(underrun),   32'd0);
        check("async_led",      32'(led_state),  32'd0);
        op_valid = 0; is_audio_sample = 0; audio_starts = 0;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
